// File: rtl/chip8_checkpoint_seq_pkg.sv
// Shared types for the CHIP-8 checkpoint sequencer: state encoding and index-width helper.
package chip8_checkpoint_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RESET = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } seq_state_t;

  // A one-entry table still needs a one-bit index.
  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/chip8_checkpoint_seq_if.sv
// Control, configuration and status bundle between a bring-up controller and the sequencer.
interface chip8_checkpoint_seq_if #(
  parameter int PROBE_W = 8,
  parameter int IDX_W   = 2,
  parameter int CYCLE_W = 16
);
  logic               start;
  logic               cfg_we;
  logic [IDX_W-1:0]   cfg_idx;
  logic [CYCLE_W-1:0] cfg_cycle;
  logic [PROBE_W-1:0] cfg_expect;
  logic [PROBE_W-1:0] cfg_mask;
  logic [IDX_W:0]     cfg_num;
  logic [PROBE_W-1:0] probe;
  logic               dut_reset_n;
  logic               busy;
  logic               done;
  logic               pass;
  logic [IDX_W:0]     fail_count;
  logic [IDX_W-1:0]   first_fail_idx;
  logic [PROBE_W-1:0] first_fail_value;

  modport master (
    output start, cfg_we, cfg_idx, cfg_cycle, cfg_expect, cfg_mask, cfg_num, probe,
    input  dut_reset_n, busy, done, pass, fail_count, first_fail_idx, first_fail_value
  );

  modport slave (
    input  start, cfg_we, cfg_idx, cfg_cycle, cfg_expect, cfg_mask, cfg_num, probe,
    output dut_reset_n, busy, done, pass, fail_count, first_fail_idx, first_fail_value
  );
endinterface

// File: rtl/chip8_seq_table.sv
// Checkpoint table: NUM_CHECKS x {cycle, expect, mask} with a synchronous write port
// and a combinational read port.
module chip8_seq_table #(
  parameter int NUM_CHECKS = 4,
  parameter int IDX_W      = 2,
  parameter int CYCLE_W    = 16,
  parameter int PROBE_W    = 8
) (
  input  logic               CLOCK_50,
  input  logic               KEY0,
  input  logic               we,
  input  logic [IDX_W-1:0]   wr_idx,
  input  logic [CYCLE_W-1:0] wr_cycle,
  input  logic [PROBE_W-1:0] wr_expect,
  input  logic [PROBE_W-1:0] wr_mask,
  input  logic [IDX_W-1:0]   rd_idx,
  output logic [CYCLE_W-1:0] rd_cycle,
  output logic [PROBE_W-1:0] rd_expect,
  output logic [PROBE_W-1:0] rd_mask
);
  logic [CYCLE_W-1:0] cycle_q  [NUM_CHECKS];
  logic [PROBE_W-1:0] expect_q [NUM_CHECKS];
  logic [PROBE_W-1:0] mask_q   [NUM_CHECKS];

  // Out-of-range indices are possible when NUM_CHECKS is not a power of two.
  always_ff @(posedge CLOCK_50 or negedge KEY0) begin
    if (!KEY0) begin
      for (int i = 0; i < NUM_CHECKS; i++) begin
        cycle_q[i]  <= '0;
        expect_q[i] <= '0;
        mask_q[i]   <= '0;
      end
    end else if (we && (int'(wr_idx) < NUM_CHECKS)) begin
      cycle_q[wr_idx]  <= wr_cycle;
      expect_q[wr_idx] <= wr_expect;
      mask_q[wr_idx]   <= wr_mask;
    end
  end

  always_comb begin
    rd_cycle  = '0;
    rd_expect = '0;
    rd_mask   = '0;
    if (int'(rd_idx) < NUM_CHECKS) begin
      rd_cycle  = cycle_q[rd_idx];
      rd_expect = expect_q[rd_idx];
      rd_mask   = mask_q[rd_idx];
    end
  end
endmodule

// File: rtl/chip8_checkpoint_seq.sv
// CHIP-8 bring-up sequencer: pulses the DUT reset, then checks a masked probe bus
// against a table of checkpoints and reports pass/fail and the first failure.
module chip8_checkpoint_seq
  import chip8_checkpoint_seq_pkg::*;
#(
  parameter int PROBE_W      = 8,
  parameter int NUM_CHECKS   = 4,
  parameter int CYCLE_W      = 16,
  parameter int RESET_CYCLES = 1
) (
  input logic                   CLOCK_50,
  input logic                   KEY0,
  chip8_checkpoint_seq_if.slave bus
);
  localparam int IDX_W  = idx_width(NUM_CHECKS);
  localparam int RCNT_W = (RESET_CYCLES <= 2) ? 1 : $clog2(RESET_CYCLES);
  localparam logic [RCNT_W-1:0] RCNT_LAST = RCNT_W'(RESET_CYCLES - 1);
  localparam logic [IDX_W:0]    MAX_NUM   = (IDX_W + 1)'(NUM_CHECKS);

  seq_state_t         state;
  logic [CYCLE_W-1:0] cnt;
  logic [IDX_W-1:0]   ptr;
  logic [IDX_W:0]     num_q;
  logic [RCNT_W-1:0]  rcnt;

  logic               dut_reset_n_q;
  logic               busy_q;
  logic               done_q;
  logic               pass_q;
  logic [IDX_W:0]     fail_count_q;
  logic [IDX_W-1:0]   first_fail_idx_q;
  logic [PROBE_W-1:0] first_fail_value_q;

  logic [CYCLE_W-1:0] rd_cycle;
  logic [PROBE_W-1:0] rd_expect;
  logic [PROBE_W-1:0] rd_mask;
  logic               table_we;
  logic               mismatch;
  logic               entry_due;
  logic               entry_last;
  logic [IDX_W:0]     num_clamped;

  assign table_we    = bus.cfg_we && ((state == IDLE) || (state == DONE));
  assign num_clamped = (bus.cfg_num > MAX_NUM) ? MAX_NUM : bus.cfg_num;
  assign mismatch    = |((bus.probe ^ rd_expect) & rd_mask);
  assign entry_due   = (cnt >= rd_cycle);
  assign entry_last  = (({1'b0, ptr} + (IDX_W + 1)'(1)) == num_q);

  chip8_seq_table #(
    .NUM_CHECKS (NUM_CHECKS),
    .IDX_W      (IDX_W),
    .CYCLE_W    (CYCLE_W),
    .PROBE_W    (PROBE_W)
  ) u_table (
    .CLOCK_50  (CLOCK_50),
    .KEY0      (KEY0),
    .we        (table_we),
    .wr_idx    (bus.cfg_idx),
    .wr_cycle  (bus.cfg_cycle),
    .wr_expect (bus.cfg_expect),
    .wr_mask   (bus.cfg_mask),
    .rd_idx    (ptr),
    .rd_cycle  (rd_cycle),
    .rd_expect (rd_expect),
    .rd_mask   (rd_mask)
  );

  always_ff @(posedge CLOCK_50 or negedge KEY0) begin
    if (!KEY0) begin
      state              <= IDLE;
      cnt                <= '0;
      ptr                <= '0;
      num_q              <= '0;
      rcnt               <= '0;
      dut_reset_n_q      <= 1'b0;
      busy_q             <= 1'b0;
      done_q             <= 1'b0;
      pass_q             <= 1'b0;
      fail_count_q       <= '0;
      first_fail_idx_q   <= '0;
      first_fail_value_q <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          dut_reset_n_q <= 1'b1;
          if (bus.start) begin
            state              <= RESET;
            num_q              <= num_clamped;
            rcnt               <= '0;
            dut_reset_n_q      <= 1'b0;
            busy_q             <= 1'b1;
            done_q             <= 1'b0;
            pass_q             <= 1'b0;
            fail_count_q       <= '0;
            first_fail_idx_q   <= '0;
            first_fail_value_q <= '0;
          end
        end
        RESET: begin
          if (rcnt == RCNT_LAST) begin
            state         <= RUN;
            dut_reset_n_q <= 1'b1;
            cnt           <= '0;
            ptr           <= '0;
          end else begin
            rcnt <= rcnt + RCNT_W'(1);
          end
        end
        RUN: begin
          // The counter saturates so late checkpoints never alias onto early cycles.
          if (cnt != '1) begin
            cnt <= cnt + CYCLE_W'(1);
          end
          if (num_q == '0) begin
            state  <= DONE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
            pass_q <= 1'b1;
          end else if (entry_due) begin
            if (mismatch) begin
              fail_count_q <= fail_count_q + (IDX_W + 1)'(1);
              if (fail_count_q == '0) begin
                first_fail_idx_q   <= ptr;
                first_fail_value_q <= bus.probe;
              end
            end
            if (entry_last) begin
              state  <= DONE;
              busy_q <= 1'b0;
              done_q <= 1'b1;
              pass_q <= !mismatch && (fail_count_q == '0);
            end else begin
              ptr <= ptr + IDX_W'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.dut_reset_n      = dut_reset_n_q;
  assign bus.busy             = busy_q;
  assign bus.done             = done_q;
  assign bus.pass             = pass_q;
  assign bus.fail_count       = fail_count_q;
  assign bus.first_fail_idx   = first_fail_idx_q;
  assign bus.first_fail_value = first_fail_value_q;
endmodule

// File: tb/tb_chip8_checkpoint_seq.sv
// Directed bench for chip8_checkpoint_seq: vector table of checkpoint runs plus
// hand-written sequences for busy-ignore, rerun, mid-run abort, reset length and saturation.
module tb_chip8_checkpoint_seq;

  typedef struct packed {
    logic [15:0] cycle;
    logic [7:0]  expv;
    logic [7:0]  mask;
  } entry_t;

  typedef struct {
    string       name;
    entry_t      e0, e1, e2, e3;
    logic [2:0]  num;
    logic [7:0]  early;
    logic [7:0]  late;
    logic [15:0] sw;
    logic        exp_pass;
    logic [2:0]  exp_fc;
    logic [1:0]  exp_ffi;
    logic [7:0]  exp_ffv;
    int          exp_lat;
  } vector_t;

  logic CLOCK_50 = 1'b0;
  logic KEY0     = 1'b0;
  always #10 CLOCK_50 = ~CLOCK_50;

  chip8_checkpoint_seq_if #(.PROBE_W(8), .IDX_W(2), .CYCLE_W(16)) bus ();
  chip8_checkpoint_seq_if #(.PROBE_W(8), .IDX_W(2), .CYCLE_W(8))  bus3 ();

  chip8_checkpoint_seq #(
    .PROBE_W(8), .NUM_CHECKS(4), .CYCLE_W(16), .RESET_CYCLES(1)
  ) dut (
    .CLOCK_50 (CLOCK_50),
    .KEY0     (KEY0),
    .bus      (bus.slave)
  );

  chip8_checkpoint_seq #(
    .PROBE_W(8), .NUM_CHECKS(4), .CYCLE_W(8), .RESET_CYCLES(3)
  ) dut3 (
    .CLOCK_50 (CLOCK_50),
    .KEY0     (KEY0),
    .bus      (bus3.slave)
  );

  int num_vectors     = 0;
  int num_miscompares = 0;

  // Probe stimulus steps from 'early' to 'late' a fixed number of cycles after DUT reset release.
  logic [15:0] rel_cnt;
  logic [7:0]  probe_early;
  logic [7:0]  probe_late;
  logic [15:0] switch_at;

  always @(posedge CLOCK_50) begin
    if (!bus.dut_reset_n) rel_cnt <= 16'd0;
    else if (rel_cnt != 16'hFFFF) rel_cnt <= rel_cnt + 16'd1;
  end

  assign bus.probe  = (rel_cnt >= switch_at) ? probe_late : probe_early;
  assign bus3.probe = 8'h44;

  function automatic entry_t mkEntry(input logic [15:0] c, input logic [7:0] e, input logic [7:0] m);
    entry_t r;
    r.cycle = c;
    r.expv  = e;
    r.mask  = m;
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    num_vectors++;
    if (actual !== expected) begin
      num_miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic writeEntry(input int idx, input entry_t e);
    @(negedge CLOCK_50);
    bus.cfg_we     = 1'b1;
    bus.cfg_idx    = idx[1:0];
    bus.cfg_cycle  = e.cycle;
    bus.cfg_expect = e.expv;
    bus.cfg_mask   = e.mask;
    @(negedge CLOCK_50);
    bus.cfg_we     = 1'b0;
  endtask

  task automatic writeEntry3(input int idx, input entry_t e);
    @(negedge CLOCK_50);
    bus3.cfg_we     = 1'b1;
    bus3.cfg_idx    = idx[1:0];
    bus3.cfg_cycle  = e.cycle[7:0];
    bus3.cfg_expect = e.expv;
    bus3.cfg_mask   = e.mask;
    @(negedge CLOCK_50);
    bus3.cfg_we     = 1'b0;
  endtask

  // Latency counts clock edges from the edge that samples start to the edge after which done is seen.
  task automatic runDut1(output int lat, output int low);
    @(negedge CLOCK_50);
    bus.start = 1'b1;
    @(negedge CLOCK_50);
    bus.start = 1'b0;
    lat = 0;
    low = (bus.dut_reset_n == 1'b0) ? 1 : 0;
    while (bus.done !== 1'b1 && lat < 400) begin
      @(negedge CLOCK_50);
      lat++;
      if (bus.dut_reset_n == 1'b0) low++;
    end
  endtask

  task automatic applyStimulus(input vector_t v);
    int lat, low;
    writeEntry(0, v.e0);
    writeEntry(1, v.e1);
    writeEntry(2, v.e2);
    writeEntry(3, v.e3);
    bus.cfg_num = v.num;
    probe_early = v.early;
    probe_late  = v.late;
    switch_at   = v.sw;
    runDut1(lat, low);
    checkOutput({v.name, ".latency"},   32'(lat), 32'(v.exp_lat));
    checkOutput({v.name, ".reset_low"}, 32'(low), 32'd1);
    checkOutput({v.name, ".busy"},      32'(bus.busy), 32'd0);
    checkOutput({v.name, ".pass"},      32'(bus.pass), 32'(v.exp_pass));
    checkOutput({v.name, ".fail_count"}, 32'(bus.fail_count), 32'(v.exp_fc));
    checkOutput({v.name, ".first_fail_idx"}, 32'(bus.first_fail_idx), 32'(v.exp_ffi));
    checkOutput({v.name, ".first_fail_value"}, 32'(bus.first_fail_value), 32'(v.exp_ffv));
  endtask

  vector_t vecs[8];
  entry_t  z;

  initial begin
    int lat, low;
    z = mkEntry(16'd0, 8'h00, 8'h00);
    vecs[0] = '{"basic_pass", mkEntry(0, 8'h00, 8'hFF), mkEntry(2, 8'h58, 8'hFF), z, z,
                3'd2, 8'h00, 8'h58, 16'd2, 1'b1, 3'd0, 2'd0, 8'h00, 4};
    vecs[1] = '{"late_fail", mkEntry(0, 8'h00, 8'hFF), mkEntry(2, 8'h58, 8'hFF), z, z,
                3'd2, 8'h00, 8'h57, 16'd2, 1'b0, 3'd1, 2'd1, 8'h57, 4};
    vecs[2] = '{"masked_nibble", mkEntry(1, 8'h50, 8'hF0), z, z, z,
                3'd1, 8'h5A, 8'h5A, 16'd0, 1'b1, 3'd0, 2'd0, 8'h00, 3};
    vecs[3] = '{"num_zero", z, z, z, z,
                3'd0, 8'h00, 8'h00, 16'd0, 1'b1, 3'd0, 2'd0, 8'h00, 2};
    vecs[4] = '{"double_fail", mkEntry(0, 8'h11, 8'hFF), mkEntry(3, 8'h22, 8'h0F), z, z,
                3'd2, 8'h10, 8'h33, 16'd1, 1'b0, 3'd2, 2'd0, 8'h10, 5};
    vecs[5] = '{"mask_zero", mkEntry(0, 8'hAA, 8'h00), mkEntry(1, 8'hBB, 8'h00), z, z,
                3'd2, 8'h12, 8'h12, 16'd0, 1'b1, 3'd0, 2'd0, 8'h00, 3};
    vecs[6] = '{"out_of_order", mkEntry(5, 8'h01, 8'hFF), mkEntry(1, 8'h02, 8'hFF), z, z,
                3'd2, 8'h01, 8'h02, 16'd6, 1'b1, 3'd0, 2'd0, 8'h00, 8};
    vecs[7] = '{"clamp_num", mkEntry(0, 8'h5A, 8'hFF), mkEntry(0, 8'h5A, 8'hFF),
                mkEntry(0, 8'h5A, 8'hFF), mkEntry(0, 8'h00, 8'hFF),
                3'd7, 8'h5A, 8'h5A, 16'd0, 1'b0, 3'd1, 2'd3, 8'h5A, 5};

    bus.start = 1'b0;  bus.cfg_we = 1'b0;  bus.cfg_idx = '0;  bus.cfg_cycle = '0;
    bus.cfg_expect = '0;  bus.cfg_mask = '0;  bus.cfg_num = '0;
    bus3.start = 1'b0; bus3.cfg_we = 1'b0; bus3.cfg_idx = '0; bus3.cfg_cycle = '0;
    bus3.cfg_expect = '0; bus3.cfg_mask = '0; bus3.cfg_num = '0;
    probe_early = 8'h00; probe_late = 8'h00; switch_at = 16'd0;

    repeat (3) @(negedge CLOCK_50);
    checkOutput("rst.dut_reset_n", 32'(bus.dut_reset_n), 32'd0);
    checkOutput("rst.busy", 32'(bus.busy), 32'd0);
    checkOutput("rst.done", 32'(bus.done), 32'd0);
    checkOutput("rst.pass", 32'(bus.pass), 32'd0);
    checkOutput("rst.fail_count", 32'(bus.fail_count), 32'd0);
    checkOutput("rst.first_fail_value", 32'(bus.first_fail_value), 32'd0);
    KEY0 = 1'b1;
    @(negedge CLOCK_50);
    checkOutput("idle.dut_reset_n", 32'(bus.dut_reset_n), 32'd1);

    for (int i = 0; i < 8; i++) begin
      $display("[TB] vector %0d: %s", i, vecs[i].name);
      applyStimulus(vecs[i]);
    end

    // Restart from DONE after a failing run; mid-run start and cfg_we must be ignored.
    $display("[TB] busy-ignore and rerun");
    writeEntry(0, mkEntry(0, 8'h00, 8'hFF));
    writeEntry(1, mkEntry(20, 8'h58, 8'hFF));
    bus.cfg_num = 3'd2;
    probe_early = 8'h00; probe_late = 8'h58; switch_at = 16'd20;
    @(negedge CLOCK_50);
    bus.start = 1'b1;
    @(negedge CLOCK_50);
    bus.start = 1'b0;
    checkOutput("restart.busy", 32'(bus.busy), 32'd1);
    checkOutput("restart.done", 32'(bus.done), 32'd0);
    checkOutput("restart.dut_reset_n", 32'(bus.dut_reset_n), 32'd0);
    checkOutput("restart.fail_count", 32'(bus.fail_count), 32'd0);
    checkOutput("restart.first_fail_idx", 32'(bus.first_fail_idx), 32'd0);
    checkOutput("restart.first_fail_value", 32'(bus.first_fail_value), 32'd0);
    lat = 0;
    repeat (5) begin
      @(negedge CLOCK_50);
      lat++;
    end
    bus.start = 1'b1; bus.cfg_we = 1'b1; bus.cfg_idx = 2'd1;
    bus.cfg_cycle = 16'd0; bus.cfg_expect = 8'hFF; bus.cfg_mask = 8'hFF;
    @(negedge CLOCK_50);
    lat++;
    bus.start = 1'b0; bus.cfg_we = 1'b0;
    while (bus.done !== 1'b1 && lat < 400) begin
      @(negedge CLOCK_50);
      lat++;
    end
    checkOutput("busy_ignore.latency", 32'(lat), 32'd22);
    checkOutput("busy_ignore.pass", 32'(bus.pass), 32'd1);
    checkOutput("busy_ignore.fail_count", 32'(bus.fail_count), 32'd0);
    runDut1(lat, low);
    checkOutput("rerun.latency", 32'(lat), 32'd22);
    checkOutput("rerun.pass", 32'(bus.pass), 32'd1);

    // Asynchronous abort mid-run, then the cleared table must let any probe pass.
    $display("[TB] mid-run abort");
    writeEntry(0, mkEntry(0, 8'hFF, 8'hFF));
    writeEntry(1, mkEntry(100, 8'h00, 8'hFF));
    probe_early = 8'h00; probe_late = 8'h00; switch_at = 16'd0;
    @(negedge CLOCK_50);
    bus.start = 1'b1;
    @(negedge CLOCK_50);
    bus.start = 1'b0;
    repeat (5) @(negedge CLOCK_50);
    checkOutput("abort.pre_fail_count", 32'(bus.fail_count), 32'd1);
    checkOutput("abort.pre_busy", 32'(bus.busy), 32'd1);
    #3 KEY0 = 1'b0;
    #1;
    checkOutput("abort.busy", 32'(bus.busy), 32'd0);
    checkOutput("abort.dut_reset_n", 32'(bus.dut_reset_n), 32'd0);
    checkOutput("abort.done", 32'(bus.done), 32'd0);
    checkOutput("abort.fail_count", 32'(bus.fail_count), 32'd0);
    checkOutput("abort.first_fail_value", 32'(bus.first_fail_value), 32'd0);
    @(negedge CLOCK_50);
    KEY0 = 1'b1;
    @(negedge CLOCK_50);
    checkOutput("abort.idle_dut_reset_n", 32'(bus.dut_reset_n), 32'd1);
    bus.cfg_num = 3'd1;
    probe_early = 8'h33; probe_late = 8'h33;
    runDut1(lat, low);
    checkOutput("cleared_table.latency", 32'(lat), 32'd2);
    checkOutput("cleared_table.pass", 32'(bus.pass), 32'd1);
    checkOutput("cleared_table.fail_count", 32'(bus.fail_count), 32'd0);

    // Three-cycle DUT reset and counter saturation on the 8-bit-counter instance.
    $display("[TB] reset length and saturation");
    writeEntry3(0, mkEntry(16'h00FF, 8'h44, 8'hFF));
    writeEntry3(1, mkEntry(16'h00FF, 8'h44, 8'hFF));
    bus3.cfg_num = 3'd2;
    @(negedge CLOCK_50);
    bus3.start = 1'b1;
    @(negedge CLOCK_50);
    bus3.start = 1'b0;
    lat = 0;
    low = (bus3.dut_reset_n == 1'b0) ? 1 : 0;
    while (bus3.done !== 1'b1 && lat < 400) begin
      @(negedge CLOCK_50);
      lat++;
      if (bus3.dut_reset_n == 1'b0) low++;
    end
    checkOutput("sat.reset_low", 32'(low), 32'd3);
    checkOutput("sat.latency", 32'(lat), 32'd260);
    checkOutput("sat.pass", 32'(bus3.pass), 32'd1);
    checkOutput("sat.fail_count", 32'(bus3.fail_count), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", num_vectors, num_miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
